ffd_pipe_chain: RTL

- Parametrised multi-stage pipeline register chain with a per-stage valid bit, valid/ready handshake, global stall, global flush and per-stage kill.
- Successor to the single enable/clear flip-flop.
- Used between RISC-V pipeline partitions, e.g. IF->ID->EX, for stall and branch-flush handling.
- Optional bubble collapsing lets younger stages advance into empty older slots while the output is stalled.

---
 rtl/ffd_pipe_chain.sv | 90 +++++++++
 1 files changed

// File: rtl/ffd_pipe_chain.sv
// Multi-stage pipeline register chain with per-stage valid, valid/ready handshake,
// global flush, per-stage kill and optional bubble collapsing while the output stalls.
module ffd_pipe_chain #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 3,
    parameter int COLLAPSE = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTH-1:0]             i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_data,
    input  logic                         i_flush,
    input  logic [DEPTH-1:0]             i_flush_mask,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_d;

    logic                        w_vin;
    logic [DEPTH-1:0]            w_ve;
    logic [DEPTH-1:0]            w_en;
    logic [DEPTH-1:0]            w_vsrc;
    logic [DEPTH-1:0][WIDTH-1:0] w_dsrc;
    logic [OCC_W-1:0]            w_occ;

    assign w_vin = i_valid & ~i_flush;
    assign w_ve  = r_v & ~({DEPTH{i_flush}} | i_flush_mask);

    // Enables resolve from the output end back towards the input
    always_comb begin
        logic en_acc;
        en_acc = i_ready;
        w_en   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (COLLAPSE != 0)
                en_acc = ~w_ve[k] | en_acc;
            else
                en_acc = i_ready | ~w_ve[DEPTH-1];
            w_en[k] = en_acc;
        end
    end

    always_comb begin
        w_vsrc    = '0;
        w_dsrc    = '0;
        w_vsrc[0] = w_vin;
        w_dsrc[0] = i_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_vsrc[k] = w_ve[k-1];
            w_dsrc[k] = r_d[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= '0;
            r_d <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_en[k]) begin
                    r_v[k] <= w_vsrc[k];
                    if (w_vsrc[k])
                        r_d[k] <= w_dsrc[k];
                end else begin
                    // a killed stage drops its beat even while stalled
                    r_v[k] <= w_ve[k];
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++)
            w_occ = w_occ + OCC_W'(r_v[k]);
    end

    assign o_ready     = w_en[0];
    assign o_valid     = w_ve[DEPTH-1];
    assign o_data      = r_d[DEPTH-1];
    assign o_occupancy = w_occ;

endmodule
